keypad_event_fifo: RTL and testbench
====================================

# keypad_event_fifo

Converts the debounced 16-bit pressed-key bitmap from the 4x4 keypad scanner into a serial stream of press and release events. Events are stored in a small FIFO for the Cortex-M0 peripheral interface to read. The block sits directly downstream of the keypad scanner in the clk domain. It gives software one 4-bit key code per event, plus an interrupt and a sticky overflow flag.

## Interface
- DEPTH, 8: FIFO depth in events; power of two, >= 2
- REL_EN, 1: 1 = generate release events; 0 = press events only
- clk  input  1  system clock; also the clock of the keypad scanner
- rstn  input  1  reset, asynchronous, active-low
- key_pulse  input  16  debounced key state; bit i = 1 while key i is held; synchronous to clk
- ev_valid  output  1  FIFO non-empty; head event is presented
- ev_ready  input  1  consumer accepts the head event
- ev_code  output  4  key index 0..15 of the head event
- ev_rel  output  1  head event type: 1 = release, 0 = press
- count  output  $clog2(DEPTH)+1  number of stored events
- ovf  output  1  sticky flag: an event was dropped because the FIFO was full
- ovf_clr  input  1  single-cycle pulse that clears ovf
- irq  output  1  ev_valid | ovf

## Operation
- key_q: registered copy of key_pulse.
- Edge detection:
  - Rising edges are key_pulse & ~key_q.
  - Falling edges are ~key_pulse & key_q; these are masked to 0 when REL_EN=0.
- Pending masks press_pend[15:0] and rel_pend[15:0]:
  - New edges are ORed into the masks.
  - An edge on a bit that is already pending merges with the pending bit; no duplicate event is produced.
- Arbiter, one event per cycle, chosen from the registered pending masks:
  - Lowest set index of press_pend wins.
  - If press_pend is empty, the lowest set index of rel_pend wins.
  - The chosen bit is cleared in the same edge that performs the FIFO write.
  - If an edge arrives on a bit in the same cycle that bit is serviced, the bit stays set.
- If both press_pend[i] and rel_pend[i] are set, the press is emitted first.
- FIFO:
  - Entry format is {rel, code[3:0]}, 5 bits.
  - First-word-fall-through: ev_code and ev_rel are valid whenever ev_valid=1.
  - Pop occurs on ev_valid & ev_ready.
  - Push is attempted whenever any pending bit is set.
- Full handling:
  - If the FIFO is full and no pop occurs that cycle, the arbitrated event is consumed anyway: its pending bit is cleared, the event is dropped and ovf is set.
  - If the FIFO is full and a pop occurs in the same cycle, the push is accepted, count is unchanged and ovf is not set.
- Empty handling: ev_ready with ev_valid=0 is ignored, and count never underflows.
- ovf:
  - Set on a dropped event.
  - Cleared by ovf_clr.
  - If set and clear occur in the same cycle, set wins.
- Pointers:
  - Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - count is tracked separately and saturates to neither bound, because bounds are never crossed.

## Timing
- Reset values: key_q=0, pending masks=0, FIFO empty, count=0, ev_valid=0, ev_code=0, ev_rel=0, ovf=0, irq=0.
- Reset is asynchronous. Assertion mid-operation flushes the FIFO and pending masks on the same clock cycle.
- After reset, a key already held (key_pulse[i]=1) produces a press event.
- Latency: if key_pulse[i] is first sampled high at edge E0, then press_pend[i] is set at E0, the FIFO write happens at E1, and ev_valid rises after E1. Total is 2 clk edges with an empty FIFO and no other pending bits.
- N keys that rise in the same cycle are written at N consecutive edges, in ascending index order.
- Pop takes effect at the clock edge: the next entry, or ev_valid=0, appears after that edge.
- irq is combinational from registered state only, so it is glitch-free relative to clk.

## Test plan
- Single press then release: key_pulse 0 -> 0x0010 held 5 cycles -> 0; ev_ready=1. Required: press event {0,4} with ev_valid 2 edges after the rise, then release event {1,4}; count returns to 0; ovf=0.
- Simultaneous presses: key_pulse 0 -> 0x8101 in one cycle; ev_ready=0. Required: FIFO holds codes 0, 8, 15 in that order, all with ev_rel=0; count=3.
- Overflow with DEPTH=8 and ev_ready=0: press and release 5 distinct keys, giving 10 events. Required: 8 stored (5 presses, 3 releases); ovf=1; irq=1; count=8. After draining, ovf remains 1 until ovf_clr.
- Full with simultaneous pop: FIFO full, ev_ready=1, new press on key 3 in the same cycle as a pop. Required: count stays 8, ovf stays 0, and key 3 is the last entry read.
- ovf_clr collision: pulse ovf_clr in the same cycle as a drop. Required: ovf=1. ovf_clr in a later idle cycle gives ovf=0; irq then follows ev_valid.
- REL_EN=0, plus reset mid-stream: with REL_EN=0, releases generate no entries. Assert rstn=0 with 4 entries stored and 2 bits pending. Required: immediately count=0, ev_valid=0, ovf=0. Keys still held at reset release produce press events.

Source files
------------

// File: rtl/keypad_event_fifo.sv
// keypad_event_fifo: turns the debounced keypad bitmap into a stream of press/release events.
// Edges are collected in pending masks, arbitrated lowest-index-first (presses before releases)
// and written one per cycle into a first-word-fall-through FIFO. Events that find the FIFO full
// are dropped and flagged in a sticky overflow bit.
module keypad_event_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter bit          REL_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [15:0]              key_pulse,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [3:0]               ev_code,
    output logic                     ev_rel,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    input  logic                     ovf_clr,
    output logic                     irq
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [15:0]   key_q;
    logic [15:0]   press_pend;
    logic [15:0]   rel_pend;
    logic [4:0]    mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count_q;
    logic          ovf_q;

    logic [15:0]   rise;
    logic [15:0]   fall;
    logic [3:0]    sel_idx;
    logic          sel_rel;
    logic          sel_valid;
    logic [15:0]   served_press;
    logic [15:0]   served_rel;
    logic          do_pop;
    logic          full;
    logic          do_push;
    logic          do_drop;

    // Edge detection against the registered key state; releases masked when disabled.
    always_comb begin
        rise = key_pulse & ~key_q;
        fall = REL_EN ? (~key_pulse & key_q) : 16'h0000;
    end

    // Arbiter: lowest pending press wins, otherwise lowest pending release.
    always_comb begin
        sel_idx      = 4'd0;
        sel_rel      = 1'b0;
        sel_valid    = 1'b0;
        served_press = 16'h0000;
        served_rel   = 16'h0000;
        if (press_pend != 16'h0000) begin
            sel_valid = 1'b1;
            for (int i = 15; i >= 0; i--) begin
                if (press_pend[i]) sel_idx = 4'(i);
            end
            served_press = 16'h0001 << sel_idx;
        end else if (rel_pend != 16'h0000) begin
            sel_valid = 1'b1;
            sel_rel   = 1'b1;
            for (int i = 15; i >= 0; i--) begin
                if (rel_pend[i]) sel_idx = 4'(i);
            end
            served_rel = 16'h0001 << sel_idx;
        end
    end

    // FIFO handshake: a full FIFO still accepts a push when it is popped in the same cycle.
    always_comb begin
        do_pop  = ev_valid & ev_ready;
        full    = (count_q == CW'(DEPTH));
        do_push = sel_valid & (~full | do_pop);
        do_drop = sel_valid & full & ~do_pop;
    end

    // State update: key history, pending masks, FIFO storage/pointers, count and overflow flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_q      <= 16'h0000;
            press_pend <= 16'h0000;
            rel_pend   <= 16'h0000;
            wptr       <= '0;
            rptr       <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 5'd0;
        end else begin
            key_q <= key_pulse;
            // A new edge on the bit being serviced re-arms it rather than being lost.
            press_pend <= (press_pend & ~served_press) | rise;
            rel_pend   <= (rel_pend & ~served_rel) | fall;
            if (do_push) begin
                mem[wptr] <= {sel_rel, sel_idx};
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
            if (do_push && !do_pop) count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
            // Set has priority over a coincident clear.
            if (do_drop) ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    // Outputs decoded from registered state only; head fields read as zero when empty.
    always_comb begin
        ev_valid = (count_q != '0);
        ev_code  = ev_valid ? mem[rptr][3:0] : 4'd0;
        ev_rel   = ev_valid ? mem[rptr][4] : 1'b0;
        count    = count_q;
        ovf      = ovf_q;
        irq      = ev_valid | ovf_q;
    end

endmodule

// File: tb/tb_keypad_event_fifo.sv
// Testbench: two instances (releases enabled / disabled) driven with the same stimulus and
// compared every cycle against an event-queue reference model.
module tb_keypad_event_fifo;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] key_pulse = 16'h0000;
    logic        ev_ready = 1'b0;
    logic        ovf_clr = 1'b0;

    logic       v0, r0, o0, i0, v1, r1, o1, i1;
    logic [3:0] c0, c1, n0, n1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    keypad_event_fifo #(.DEPTH(DEPTH), .REL_EN(1'b1)) dut0 (
        .clk(clk), .rstn(rstn), .key_pulse(key_pulse), .ev_valid(v0), .ev_ready(ev_ready),
        .ev_code(c0), .ev_rel(r0), .count(n0), .ovf(o0), .ovf_clr(ovf_clr), .irq(i0)
    );

    keypad_event_fifo #(.DEPTH(DEPTH), .REL_EN(1'b0)) dut1 (
        .clk(clk), .rstn(rstn), .key_pulse(key_pulse), .ev_valid(v1), .ev_ready(ev_ready),
        .ev_code(c1), .ev_rel(r1), .count(n1), .ovf(o1), .ovf_clr(ovf_clr), .irq(i1)
    );

    // Reference model state: last keys seen, pending key sets, event queues, overflow flags.
    logic [15:0] m_kq [2];
    logic [15:0] m_pp [2];
    logic [15:0] m_rp [2];
    bit          m_ovf [2];
    logic [4:0]  q0 [$];
    logic [4:0]  q1 [$];

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int qsize(input int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [4:0] qfront(input int m);
        return (m == 0) ? q0[0] : q1[0];
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_kq[m] = 16'h0; m_pp[m] = 16'h0; m_rp[m] = 16'h0; m_ovf[m] = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    // One clock edge of the behavioural model for instance m.
    task automatic model_step(input int m, input logic [15:0] kp, input bit rdy, input bit clr);
        bit          pop, have, rel, drop;
        int          idx;
        logic [15:0] rise, fall;
        pop  = (qsize(m) > 0) && rdy;
        rise = kp & ~m_kq[m];
        fall = (m == 0) ? (~kp & m_kq[m]) : 16'h0;
        have = 1'b0; rel = 1'b0; idx = 0; drop = 1'b0;
        if (m_pp[m] != 0) begin
            have = 1'b1;
            for (int i = 15; i >= 0; i--) if (m_pp[m][i]) idx = i;
            m_pp[m][idx] = 1'b0;
        end else if (m_rp[m] != 0) begin
            have = 1'b1; rel = 1'b1;
            for (int i = 15; i >= 0; i--) if (m_rp[m][i]) idx = i;
            m_rp[m][idx] = 1'b0;
        end
        if (pop) begin
            if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (have) begin
            if (qsize(m) < int'(DEPTH)) begin
                if (m == 0) q0.push_back({rel, 4'(idx)}); else q1.push_back({rel, 4'(idx)});
            end else begin
                drop = 1'b1;
            end
        end
        m_pp[m] = m_pp[m] | rise;
        m_rp[m] = m_rp[m] | fall;
        if (drop) m_ovf[m] = 1'b1;
        else if (clr) m_ovf[m] = 1'b0;
        m_kq[m] = kp;
    endtask

    task automatic compare_outputs();
        bit         ev;
        logic [4:0] h;
        for (int m = 0; m < 2; m++) begin
            ev = qsize(m) > 0;
            h  = ev ? qfront(m) : 5'd0;
            check_eq($sformatf("valid%0d", m), (m == 0) ? v0 : v1, ev);
            check_eq($sformatf("code%0d", m), (m == 0) ? c0 : c1, h[3:0]);
            check_eq($sformatf("rel%0d", m), (m == 0) ? r0 : r1, h[4]);
            check_eq($sformatf("count%0d", m), (m == 0) ? n0 : n1, qsize(m));
            check_eq($sformatf("ovf%0d", m), (m == 0) ? o0 : o1, m_ovf[m]);
            check_eq($sformatf("irq%0d", m), (m == 0) ? i0 : i1, ev | m_ovf[m]);
        end
    endtask

    // Drive inputs after a falling edge, clock once, advance the model, check at the next fall.
    task automatic cycle(input logic [15:0] kp, input bit rdy, input bit clr);
        key_pulse = kp; ev_ready = rdy; ovf_clr = clr;
        @(posedge clk);
        model_step(0, kp, rdy, clr);
        model_step(1, kp, rdy, clr);
        @(negedge clk);
        compare_outputs();
    endtask

    // Asynchronous reset between clock edges; flush must be visible before any edge.
    task automatic async_reset();
        #2 rstn = 1'b0;
        #1;
        check_eq("rst_count", n0, 0);
        check_eq("rst_valid", v0, 0);
        check_eq("rst_ovf", o0, 0);
        check_eq("rst_irq", i0, 0);
        check_eq("rst_count1", n1, 0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        compare_outputs();
    endtask

    initial begin
        logic [15:0] kp;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        compare_outputs();

        // Single press then release of key 4, with the two-edge latency checked explicitly.
        cycle(16'h0010, 1'b1, 1'b0);
        check_eq("lat_e0_valid", v0, 0);
        cycle(16'h0010, 1'b1, 1'b0);
        check_eq("lat_e1_valid", v0, 1);
        check_eq("lat_e1_code", c0, 4);
        for (int i = 0; i < 3; i++) cycle(16'h0010, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(16'h0000, 1'b1, 1'b0);
        check_eq("single_count", n0, 0);

        // Simultaneous presses of keys 0, 8 and 15 with no consumer.
        for (int i = 0; i < 5; i++) cycle(16'h8101, 1'b0, 1'b0);
        check_eq("simul_count", n0, 3);
        check_eq("simul_head", c0, 0);
        for (int i = 0; i < 8; i++) cycle(16'h0000, 1'b1, 1'b0);

        // Overflow: five keys pressed and released, ten events into eight slots.
        kp = 16'h0000;
        for (int k = 1; k <= 5; k++) begin
            kp[k] = 1'b1;
            cycle(kp, 1'b0, 1'b0);
        end
        for (int k = 1; k <= 5; k++) begin
            kp[k] = 1'b0;
            cycle(kp, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) cycle(kp, 1'b0, 1'b0);
        check_eq("ovf_count", n0, 8);
        check_eq("ovf_flag", o0, 1);
        for (int i = 0; i < 10; i++) cycle(kp, 1'b1, 1'b0);
        check_eq("drain_ovf_sticky", o0, 1);
        cycle(kp, 1'b0, 1'b1);
        check_eq("ovf_cleared", o0, 0);

        // Randomised traffic with occasional mid-cycle resets.
        kp = 16'h0000;
        for (int n = 0; n < 4000; n++) begin
            bit rdy;
            if ($urandom_range(3) == 0) kp[$urandom_range(15)] ^= 1'b1;
            if ($urandom_range(7) == 0) kp ^= 16'($urandom());
            rdy = ((n / 200) % 2 == 0) ? ($urandom_range(3) != 0) : ($urandom_range(7) == 0);
            cycle(kp, rdy, $urandom_range(15) == 0);
            if ($urandom_range(499) == 0) async_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
